// File: rtl/draw_rect_ctl.sv
// Frame-rate position controller: follows the mouse, or drops the rectangle under gravity
// with damped bounces off the floor, updating once per vsync rising edge.
module draw_rect_ctl #(
    parameter int unsigned YMAX       = 600,
    parameter int unsigned RECT_H     = 64,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned MIN_BOUNCE = 2,
    parameter int unsigned VMAX       = 63
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        vsync_in,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        falling
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFall = 2'd1;
    localparam logic [1:0] StRise = 2'd2;
    localparam logic [1:0] StStop = 2'd3;

    localparam logic [11:0] Floor = 12'(YMAX - RECT_H);
    localparam logic [6:0]  Grav  = 7'(GRAVITY);
    localparam logic [6:0]  VMax  = 7'(VMAX);
    localparam logic [6:0]  MinB  = 7'(MIN_BOUNCE);

    logic [1:0]  state_q, state_d;
    logic [6:0]  vel_q, vel_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        falling_q, falling_d;
    logic        vsync_q;
    logic        tick;

    logic [7:0]  vel_inc;
    logic [6:0]  vn;
    logic [6:0]  vel_bounce;
    logic [12:0] ny;
    logic [6:0]  vel_dec;

    assign tick = vsync_in & ~vsync_q;

    always_comb begin
        // Saturating fall velocity and candidate position, widened so nothing wraps
        vel_inc    = {1'b0, vel_q} + {1'b0, Grav};
        vn         = (vel_inc > {1'b0, VMax}) ? VMax : vel_inc[6:0];
        ny         = {1'b0, ypos_q} + {6'b0, vn};
        vel_bounce = vn - (vn >> 2);
        vel_dec    = (vel_q > Grav) ? (vel_q - Grav) : 7'd0;

        state_d = state_q;
        vel_d   = vel_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;

        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    xpos_d = mouse_xpos;
                    ypos_d = (mouse_ypos > Floor) ? Floor : mouse_ypos;
                    if (mouse_left) begin
                        state_d = StFall;
                        vel_d   = 7'd0;
                    end
                end
                StFall: begin
                    if (ny < {1'b0, Floor}) begin
                        ypos_d = ny[11:0];
                        vel_d  = vn;
                    end else begin
                        ypos_d = Floor;
                        if (vn > MinB) begin
                            vel_d   = vel_bounce;
                            state_d = StRise;
                        end else begin
                            vel_d   = 7'd0;
                            state_d = StStop;
                        end
                    end
                end
                StRise: begin
                    ypos_d = (ypos_q >= {5'b0, vel_q}) ? (ypos_q - {5'b0, vel_q}) : 12'd0;
                    vel_d  = vel_dec;
                    if (vel_dec == 7'd0) begin
                        state_d = StFall;
                    end
                end
                StStop: begin
                    ypos_d = Floor;
                    if (!mouse_left) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        falling_d = (state_d == StFall) || (state_d == StRise);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            vel_q     <= 7'd0;
            xpos_q    <= 12'd0;
            ypos_q    <= 12'd0;
            falling_q <= 1'b0;
            vsync_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            if (tick) begin
                state_q   <= state_d;
                vel_q     <= vel_d;
                xpos_q    <= xpos_d;
                ypos_q    <= ypos_d;
                falling_q <= falling_d;
            end
        end
    end

    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign falling = falling_q;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Bench for draw_rect_ctl: directed trajectories plus randomized frames checked against a
// per-frame physics model, on a default instance and a short-floor, heavy-gravity instance.
module tb_draw_rect_ctl;

    logic        pclk;
    logic        rst;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        vsync_in;
    logic [11:0] xpos, ypos, xpos_b, ypos_b;
    logic        falling, falling_b;

    int checks = 0;
    int errors = 0;

    draw_rect_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .vsync_in   (vsync_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .falling    (falling)
    );

    // Floor at 10, gravity 8: rises overshoot the top edge and must clamp at 0
    draw_rect_ctl #(
        .YMAX       (600),
        .RECT_H     (590),
        .GRAVITY    (8),
        .MIN_BOUNCE (12),
        .VMAX       (63)
    ) dut_b (
        .pclk       (pclk),
        .rst        (rst),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .vsync_in   (vsync_in),
        .xpos       (xpos_b),
        .ypos       (ypos_b),
        .falling    (falling_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model: one call per frame, modes 0 follow, 1 drop, 2 rise, 3 rest
    typedef struct {
        int mode;
        int x;
        int y;
        int v;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t s, int mx, int my, bit ml, int flr, int g, int minb,
                                  int vmax);
        mdl_t n = s;
        int vn;
        if (s.mode == 0) begin
            n.x = mx;
            n.y = (my < flr) ? my : flr;
            if (ml) begin
                n.mode = 1;
                n.v = 0;
            end
        end else if (s.mode == 1) begin
            vn = s.v + g;
            if (vn > vmax) vn = vmax;
            if (s.y + vn < flr) begin
                n.y = s.y + vn;
                n.v = vn;
            end else begin
                n.y = flr;
                if (vn > minb) begin
                    n.v = vn - vn / 4;
                    n.mode = 2;
                end else begin
                    n.v = 0;
                    n.mode = 3;
                end
            end
        end else if (s.mode == 2) begin
            n.y = (s.y >= s.v) ? s.y - s.v : 0;
            n.v = (s.v > g) ? s.v - g : 0;
            if (n.v == 0) n.mode = 1;
        end else begin
            n.y = flr;
            if (!ml) n.mode = 0;
        end
        return n;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.mode = 0;
        r.x = 0;
        r.y = 0;
        r.v = 0;
        return r;
    endfunction

    task automatic do_tick(input int hold);
        vsync_in = 1'b1;
        @(posedge pclk);
        #1;
        for (int i = 1; i < hold; i++) begin
            @(posedge pclk);
            #1;
        end
        vsync_in = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge pclk);
        #1;
        rst = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        vsync_in = 1'b0;
        mouse_left = 1'b0;
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd200;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || falling !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got x=%0d y=%0d f=%0b want 0 0 0", xpos, ypos, falling);
        end
        rst = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        mouse_left = 1'b1;
        do_tick(1);
        mouse_left = 1'b0;
        do_tick(1);
        checks++;
        if (falling !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefall got f=%0b want 1", falling);
        end
        // Asynchronous reset in the middle of a frame while falling
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || falling !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got x=%0d y=%0d f=%0b want 0 0 0", xpos, ypos, falling);
        end
        rst = 1'b1;
        @(posedge pclk);
        #1;
        checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0) begin
            errors++;
            $display("FAIL reset_hold got x=%0d y=%0d want 0 0", xpos, ypos);
        end
        do_tick(1);
        checks++;
        if (xpos !== 12'd300 || ypos !== 12'd200 || falling !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_tick got x=%0d y=%0d f=%0b want 300 200 0",
                     xpos, ypos, falling);
        end
    endtask

    task automatic test_follow_clamp();
        int bad = 0;
        do_reset();
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd590;
        do_tick(1);
        checks++;
        if (xpos !== 12'd100 || ypos !== 12'd536) begin
            errors++;
            $display("FAIL follow_clamp got x=%0d y=%0d want 100 536", xpos, ypos);
        end
        for (int i = 0; i < 5000; i++) begin
            mouse_xpos = 12'($urandom_range(0, 1023));
            mouse_ypos = 12'($urandom_range(0, 700));
            mouse_left = 1'($urandom);
            @(posedge pclk);
            #1;
            if (xpos !== 12'd100 || ypos !== 12'd536 || falling !== 1'b0) bad++;
        end
        mouse_left = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_tick_hold got %0d cycles changed want 0 (x=%0d y=%0d)",
                     bad, xpos, ypos);
        end
    endtask

    task automatic test_fall_bounce();
        int exp_y [0:21];
        exp_y = '{501, 503, 506, 510, 515, 521, 528, 536,
                  530, 525, 521, 518, 516, 515,
                  516, 518, 521, 525, 530, 536,
                  531, 527};
        do_reset();
        mouse_xpos = 12'd400;
        mouse_ypos = 12'd500;
        mouse_left = 1'b1;
        do_tick(1);
        checks++;
        if (xpos !== 12'd400 || ypos !== 12'd500 || falling !== 1'b1) begin
            errors++;
            $display("FAIL click got x=%0d y=%0d f=%0b want 400 500 1", xpos, ypos, falling);
        end
        for (int i = 0; i < 22; i++) begin
            // Mouse moves and clicks mid-flight must not disturb the trajectory
            mouse_left = (i % 3 == 1);
            mouse_xpos = 12'($urandom_range(0, 1023));
            mouse_ypos = 12'($urandom_range(0, 700));
            do_tick(1 + (i % 2));
            checks++;
            if (ypos !== 12'(exp_y[i]) || xpos !== 12'd400 || falling !== 1'b1) begin
                errors++;
                $display("FAIL fall_step[%0d] got x=%0d y=%0d f=%0b want 400 %0d 1",
                         i, xpos, ypos, falling, exp_y[i]);
            end
        end
        mouse_left = 1'b0;
    endtask

    task automatic test_stop_release();
        do_reset();
        mouse_xpos = 12'd200;
        mouse_ypos = 12'd535;
        mouse_left = 1'b1;
        do_tick(1);
        do_tick(1);
        checks++;
        if (ypos !== 12'd536 || falling !== 1'b0 || xpos !== 12'd200) begin
            errors++;
            $display("FAIL stop_entry got x=%0d y=%0d f=%0b want 200 536 0", xpos, ypos, falling);
        end
        for (int i = 0; i < 3; i++) begin
            mouse_xpos = 12'd50 + 12'(i);
            mouse_ypos = 12'd100;
            do_tick(1);
            checks++;
            if (ypos !== 12'd536 || xpos !== 12'd200 || falling !== 1'b0) begin
                errors++;
                $display("FAIL stop_held[%0d] got x=%0d y=%0d f=%0b want 200 536 0",
                         i, xpos, ypos, falling);
            end
        end
        mouse_left = 1'b0;
        mouse_xpos = 12'd50;
        mouse_ypos = 12'd100;
        do_tick(1);
        checks++;
        if (ypos !== 12'd536 || xpos !== 12'd200 || falling !== 1'b0) begin
            errors++;
            $display("FAIL release_tick got x=%0d y=%0d f=%0b want 200 536 0",
                     xpos, ypos, falling);
        end
        do_tick(1);
        checks++;
        if (ypos !== 12'd100 || xpos !== 12'd50 || falling !== 1'b0) begin
            errors++;
            $display("FAIL release_follow got x=%0d y=%0d f=%0b want 50 100 0",
                     xpos, ypos, falling);
        end
    endtask

    task automatic test_top_clamp();
        int exp_y [0:5];
        exp_y = '{8, 10, 0, 0, 8, 10};
        do_reset();
        mouse_xpos = 12'd20;
        mouse_ypos = 12'd0;
        mouse_left = 1'b1;
        do_tick(1);
        mouse_left = 1'b0;
        checks++;
        if (ypos_b !== 12'd0 || xpos_b !== 12'd20 || falling_b !== 1'b1) begin
            errors++;
            $display("FAIL top_click got x=%0d y=%0d f=%0b want 20 0 1", xpos_b, ypos_b, falling_b);
        end
        for (int i = 0; i < 6; i++) begin
            do_tick(1);
            checks++;
            if (ypos_b !== 12'(exp_y[i]) || falling_b !== 1'b1) begin
                errors++;
                $display("FAIL top_clamp[%0d] got y=%0d f=%0b want %0d 1",
                         i, ypos_b, falling_b, exp_y[i]);
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        int mx, my;
        bit ml;
        do_reset();
        ma = mdl_reset();
        mb = mdl_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                checks++;
                if (xpos !== 12'd0 || ypos !== 12'd0 || falling !== 1'b0 ||
                    ypos_b !== 12'd0 || falling_b !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_reset[%0d] got x=%0d y=%0d f=%0b want 0 0 0",
                             i, xpos, ypos, falling);
                end
                rst = 1'b1;
                @(posedge pclk);
                #1;
                ma = mdl_reset();
                mb = mdl_reset();
            end
            mx = $urandom_range(0, 1023);
            my = ($urandom_range(0, 2) == 0) ? $urandom_range(525, 600) : $urandom_range(0, 700);
            ml = ($urandom_range(0, 3) == 0);
            mouse_xpos = 12'(mx);
            mouse_ypos = 12'(my);
            mouse_left = ml;
            repeat ($urandom_range(0, 3)) @(posedge pclk);
            #1;
            do_tick($urandom_range(1, 4));
            ma = step(ma, mx, my, ml, 536, 1, 2, 63);
            mb = step(mb, mx, my, ml, 10, 8, 12, 63);
            checks++;
            if (xpos !== 12'(ma.x) || ypos !== 12'(ma.y) ||
                falling !== (ma.mode == 1 || ma.mode == 2)) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_a[%0d] got x=%0d y=%0d f=%0b want %0d %0d %0b",
                             i, xpos, ypos, falling, ma.x, ma.y, (ma.mode == 1 || ma.mode == 2));
            end
            checks++;
            if (xpos_b !== 12'(mb.x) || ypos_b !== 12'(mb.y) ||
                falling_b !== (mb.mode == 1 || mb.mode == 2)) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_b[%0d] got x=%0d y=%0d f=%0b want %0d %0d %0b",
                             i, xpos_b, ypos_b, falling_b, mb.x, mb.y,
                             (mb.mode == 1 || mb.mode == 2));
            end
        end
        mouse_left = 1'b0;
    endtask

    initial begin
        test_reset();
        test_follow_clamp();
        test_fall_bounce();
        test_stop_release();
        test_top_clamp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_rect_ctl.md
Name: draw_rect_ctl

Overview:
- Frame-rate position controller that produces xpos/ypos for the rectangle/image drawing stage directly downstream.
- In IDLE the rectangle follows the mouse.
- A left click freezes x and drops the rectangle under constant gravity. It bounces off a floor with damping and stops.
- It returns to mouse-follow after the button is released.
- All motion updates once per frame, on the rising edge of vsync.

Parameters:
- YMAX, 600, visible screen height in pixels.
- RECT_H, 64, rectangle height. FLOOR = YMAX - RECT_H = 536 is the lowest allowed ypos.
- GRAVITY, 1, velocity increment per frame (pixels/frame²).
- MIN_BOUNCE, 2, impact velocity at or below which the rectangle stops instead of bouncing.
- VMAX, 63, velocity saturation limit.

Ports:
- pclk  in  1  pixel clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- mouse_xpos  in  12  mouse x (from mouse decoder, already in pclk domain).
- mouse_ypos  in  12  mouse y.
- mouse_left  in  1  left button level, 1 = pressed.
- vsync_in  in  1  vertical sync from timing chain, active-high.
- xpos  out  12  rectangle x, to drawing stage.
- ypos  out  12  rectangle y, to drawing stage.
- falling  out  1  high while in FALL or RISE.

Behaviour:
- Reset (rst=0, async): xpos=0, ypos=0, vel=0, vsync_d=0, state=IDLE, falling=0. Outputs hold these values until the first tick after rst deasserts.
- vsync_d is a register of vsync_in.
- tick = vsync_in & ~vsync_d (combinational).
- All state, xpos, ypos and vel update only on a pclk edge where tick=1. Otherwise everything holds.
- Latency: outputs change on the same pclk edge that first samples vsync_in=1 after a 0.
- vel is an unsigned 7-bit internal register.
- Arithmetic is 12-bit unsigned with explicit clamping; no wrap-around allowed.
- IDLE:
  - xpos=mouse_xpos; ypos=min(mouse_ypos, FLOOR).
  - If mouse_left=1 at the tick: state goes to FALL and vel=0. xpos/ypos take the mouse values on this same tick.
- FALL:
  - xpos held. vn = min(vel+GRAVITY, VMAX). ny = ypos + vn.
  - If ny < FLOOR: ypos=ny, vel=vn.
  - If ny >= FLOOR: ypos=FLOOR. Then:
    - if vn > MIN_BOUNCE: vel = vn - (vn>>2), state goes to RISE;
    - else vel=0, state goes to STOP.
- RISE:
  - ypos = (ypos >= vel) ? ypos - vel : 0.
  - vel = (vel > GRAVITY) ? vel - GRAVITY : 0.
  - If the new vel = 0, state goes to FALL.
- STOP:
  - ypos=FLOOR, xpos held.
  - If mouse_left=0 at the tick, state goes to IDLE. The new mouse position is taken on the following tick.
- mouse_left is ignored in FALL and RISE.
- A held button in STOP keeps the rectangle in STOP.
- falling = 1 in FALL or RISE, registered together with the state.
- Reset mid-motion returns immediately to the reset values.
- vsync_in held high produces exactly one tick.

Test Plan:
- Reset:
  - Stimulus: rst=0 mid-frame with mouse at (300,200).
  - Required: xpos=0, ypos=0, falling=0 immediately. After rst=1, the first tick gives xpos=300, ypos=200.
- Follow and clamp:
  - Stimulus: IDLE, mouse (100,590), one tick.
  - Required: xpos=100, ypos=536.
  - Stimulus: no vsync edge for 5000 cycles with the mouse moving.
  - Required: outputs unchanged.
- Fall trajectory:
  - Stimulus: mouse (400,500), mouse_left=1 on a tick, then release.
  - Required on successive ticks: ypos 501, 503, 506, 510, 515, 521, 528, 536. At 536 the state goes to RISE with vel=6. xpos stays 400.
- Bounce:
  - Stimulus: continue from the fall trajectory.
  - Required: ypos 530, 525, 521, 518, 516, 515. Then FALL from vel=0: 516, 518, 521, 525, 530, 536 (vn=6, so vel=5, RISE).
  - Required: this repeats until impact vn ≤ 2, after which the state is STOP with falling=0.
- Stop and release:
  - Stimulus: in STOP, mouse_left held 1 for 3 ticks.
  - Required: ypos stays 536.
  - Stimulus: release at a tick.
  - Required: state goes to IDLE, and the next tick tracks the mouse.
- Click ignored mid-flight and top clamp:
  - Stimulus: click pulses during FALL/RISE.
  - Required: trajectory unchanged.
  - Stimulus: with RECT_H=590, a RISE with ypos=3, vel=6.
  - Required: ypos=0, no underflow.
